// File: rtl/matrix_result_reader_if.sv
// Row-major element stream from the result reader.
// Plain valid/ready handshake with element coordinates and a last marker.
interface matrix_result_reader_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_reader.sv
// Snapshots an NxN result matrix on the rising edge of done_in and
// streams it row-major over a valid/ready interface.
module matrix_result_reader #(
    parameter int N      = 4,
    parameter int DATA_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              done_in,
    input  logic [0:N-1][0:N-1][DATA_W-1:0]   c_in,
    matrix_result_reader_if.master            strm,
    output logic                              busy,
    output logic                              overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [1:0] LAST = 2'(N - 1);

    state_t state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [0:N-1][0:N-1][DATA_W-1:0] snap_q;
    logic done_q;
    logic load;
    logic ovr_set;
    logic cap;
    logic at_end;
    logic valid;
    logic xfer;

    assign cap    = done_in && !done_q;
    assign at_end = (row_q == LAST) && (col_q == LAST);
    assign valid  = (state_q == STREAM);
    assign xfer   = valid && strm.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_in;
            if (load)
                snap_q <= c_in;
            if (ovr_set)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_end) begin
                    row_d = '0;
                    col_d = '0;
                    // A new result landing on the final beat chains straight on
                    if (cap)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    if (xfer) begin
                        if (col_q == LAST) begin
                            col_d = '0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                    if (cap)
                        ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign strm.out_valid = valid;
    assign strm.out_data  = valid ? snap_q[row_q][col_q] : '0;
    assign strm.out_row   = valid ? row_q : 2'd0;
    assign strm.out_col   = valid ? col_q : 2'd0;
    assign strm.out_last  = valid && at_end;
    assign busy           = valid;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed bench for matrix_result_reader: streaming, stalls, overrun,
// chained capture on the final beat and mid-stream reset.
module tb_matrix_result_reader;

    logic clk = 1'b0;
    logic rst;
    logic done_in;
    logic busy;
    logic overrun;
    logic [0:3][0:3][15:0] c_in;
    int nvec = 0;
    int nerr = 0;

    matrix_result_reader_if #(.DATA_W(16)) bus ();

    matrix_result_reader #(.N(4), .DATA_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .done_in (done_in),
        .c_in    (c_in),
        .strm    (bus.master),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = 16'(16 * i + j);
    endtask

    task automatic load_const(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in[i][j] = v;
    endtask

    task automatic pulse_done();
        done_in = 1'b0;
        tick();
        done_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        done_in = 1'b1;
        bus.out_ready = 1'b1;
        load_ramp();
        tick();
        tick();
        rst = 1'b0;
        nvec++;
        if ({bus.out_valid, bus.out_last, busy, overrun} !== 4'b0) begin
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.out_valid, bus.out_last, busy, overrun});
            nerr++;
        end
        nvec++;
        if ({bus.out_data, bus.out_row, bus.out_col} !== 20'h0) begin
            $display("FAIL reset_data got %h exp 0",
                     {bus.out_data, bus.out_row, bus.out_col});
            nerr++;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                $display("FAIL held_done_capture c=%0d got %b exp 0",
                         c, bus.out_valid);
                nerr++;
            end
        end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        load_ramp();
        pulse_done();
        for (int k = 0; k < 16; k++) begin
            e = 16'(16 * (k / 4) + k % 4);
            nvec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                $display("FAIL stream k=%0d got v=%b d=%h exp v=1 d=%h",
                         k, bus.out_valid, bus.out_data, e);
                nerr++;
            end
            nvec++;
            if (bus.out_row !== 2'(k / 4) || bus.out_col !== 2'(k % 4)
                || bus.out_last !== (k == 15)) begin
                $display("FAIL stream_idx k=%0d got r=%0d c=%0d l=%b",
                         k, bus.out_row, bus.out_col, bus.out_last);
                nerr++;
            end
            tick();
        end
        nvec++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL stream_end got v=%b busy=%b exp 0 0",
                     bus.out_valid, busy);
            nerr++;
        end
    endtask

    task automatic test_stall();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] e;
        int k = 0;
        load_ramp();
        pulse_done();
        for (int c = 0; c < 200 && k < 16; c++) begin
            e = 16'(16 * (k / 4) + k % 4);
            nvec++;
            if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_data !== e
                || bus.out_row !== 2'(k / 4) || bus.out_col !== 2'(k % 4)
                || bus.out_last !== (k == 15)) begin
                $display("FAIL stall c=%0d k=%0d got v=%b b=%b d=%h r=%0d c=%0d l=%b exp d=%h",
                         c, k, bus.out_valid, busy, bus.out_data,
                         bus.out_row, bus.out_col, bus.out_last, e);
                nerr++;
            end
            bus.out_ready = pat[c % 4];
            tick();
            if (pat[c % 4])
                k++;
        end
        bus.out_ready = 1'b1;
        nvec++;
        if (k !== 16 || bus.out_valid !== 1'b0) begin
            $display("FAIL stall_end got k=%0d v=%b exp 16 0", k, bus.out_valid);
            nerr++;
        end
    endtask

    task automatic test_overrun();
        logic [15:0] e;
        load_ramp();
        pulse_done();
        done_in = 1'b0;
        nvec++;
        if (overrun !== 1'b0) begin
            $display("FAIL overrun_pre got %b exp 0", overrun);
            nerr++;
        end
        for (int k = 0; k < 16; k++) begin
            e = 16'(16 * (k / 4) + k % 4);
            nvec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                $display("FAIL overrun_data k=%0d got %h exp %h",
                         k, bus.out_data, e);
                nerr++;
            end
            if (k == 5) begin
                done_in = 1'b1;
                load_const(16'hFFFF);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            nvec++;
            if (overrun !== 1'b1 || bus.out_valid !== 1'b0) begin
                $display("FAIL overrun_sticky c=%0d got ov=%b v=%b exp 1 0",
                         c, overrun, bus.out_valid);
                nerr++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if (overrun !== 1'b0) begin
            $display("FAIL overrun_clear got %b exp 0", overrun);
            nerr++;
        end
        load_ramp();
        pulse_done();
        done_in = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e = 16'(16 * (k / 4) + k % 4);
            nvec++;
            if (bus.out_data !== e) begin
                $display("FAIL b2b_first k=%0d got %h exp %h", k, bus.out_data, e);
                nerr++;
            end
            if (k == 15) begin
                done_in = 1'b1;
                load_const(16'h00AA);
            end
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            nvec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00AA
                || bus.out_row !== 2'(k / 4) || bus.out_col !== 2'(k % 4)
                || bus.out_last !== (k == 15)) begin
                $display("FAIL b2b_second k=%0d got v=%b d=%h r=%0d c=%0d l=%b exp d=00aa",
                         k, bus.out_valid, bus.out_data, bus.out_row,
                         bus.out_col, bus.out_last);
                nerr++;
            end
            tick();
        end
        nvec++;
        if (overrun !== 1'b0 || bus.out_valid !== 1'b0) begin
            $display("FAIL b2b_end got ov=%b v=%b exp 0 0", overrun, bus.out_valid);
            nerr++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        load_ramp();
        pulse_done();
        for (int k = 0; k < 7; k++) begin
            e = 16'(16 * (k / 4) + k % 4);
            nvec++;
            if (bus.out_data !== e) begin
                $display("FAIL mid_pre k=%0d got %h exp %h", k, bus.out_data, e);
                nerr++;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        nvec++;
        if ({bus.out_valid, bus.out_last, busy, overrun, bus.out_data,
             bus.out_row, bus.out_col} !== 24'h0) begin
            $display("FAIL mid_reset got v=%b d=%h r=%0d c=%0d exp all 0",
                     bus.out_valid, bus.out_data, bus.out_row, bus.out_col);
            nerr++;
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                $display("FAIL mid_no_restart c=%0d got %b exp 0", c, bus.out_valid);
                nerr++;
            end
        end
        pulse_done();
        nvec++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000
            || bus.out_row !== 2'd0 || bus.out_col !== 2'd0) begin
            $display("FAIL mid_restart got v=%b d=%h r=%0d c=%0d exp 1 0000 0 0",
                     bus.out_valid, bus.out_data, bus.out_row, bus.out_col);
            nerr++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
